// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the memory stage.
// Holds the MEM FSM state and the EX/MEM and MEM/WB bundles.
package pipeline_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [XLEN-1:0]      aluOut;
        logic [XLEN-1:0]      rd3;
        logic [REG_IDX_W-1:0] Rc;
        logic                 memWrite;
        logic                 memToReg;
        logic                 regWrite;
    } ex_mem_t;

    typedef struct packed {
        logic [XLEN-1:0]      result;
        logic [REG_IDX_W-1:0] Rc;
        logic                 regWrite;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
// load sets valid and captures the bundle; clear drops valid only.
module mem_wb_reg
    import pipeline_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 clear_i,
    input  logic [N-1:0]         result_i,
    input  logic [REG_IDX_W-1:0] rc_i,
    input  logic                 regwrite_i,
    output logic                 valid_o,
    output logic [N-1:0]         result_o,
    output logic [REG_IDX_W-1:0] rc_o,
    output logic                 regwrite_o
);

    logic                 valid_q;
    logic [N-1:0]         result_q;
    logic [REG_IDX_W-1:0] rc_q;
    logic                 rw_q;

    // Load beats clear; with neither asserted everything holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            rc_q     <= '0;
            rw_q     <= 1'b0;
        end else if (load_i) begin
            valid_q  <= 1'b1;
            result_q <= result_i;
            rc_q     <= rc_i;
            rw_q     <= regwrite_i;
        end else if (clear_i) begin
            valid_q  <= 1'b0;
        end
    end

    assign valid_o    = valid_q;
    assign result_o   = result_q;
    assign rc_o       = rc_q;
    assign regwrite_o = rw_q;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: data-memory req/ack access, stall and timeout abort.
// ALU results pass straight into the MEM/WB register.
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int N       = 32,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 ex_valid,
    input  logic [N-1:0]         aluOut,
    input  logic [N-1:0]         rd3,
    input  logic [REG_IDX_W-1:0] Rc,
    input  logic                 memWrite,
    input  logic                 memToReg,
    input  logic                 regWrite,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [ADDR_W-1:0]    dmem_addr,
    output logic [N-1:0]         dmem_wdata,
    input  logic [N-1:0]         dmem_rdata,
    input  logic                 dmem_ack,
    output logic                 mem_stall,
    output logic                 wb_valid,
    output logic [N-1:0]         wb_result,
    output logic [REG_IDX_W-1:0] wb_Rc,
    output logic                 wb_regWrite,
    output logic                 mem_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    mem_state_t           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [N-1:0]         wdata_q, wdata_d;
    logic [REG_IDX_W-1:0] rc_q, rc_d;
    logic                 rw_q, rw_d;
    logic                 ld_q, ld_d;
    logic                 err_q, err_d;

    logic                 wb_load, wb_clr;
    logic [N-1:0]         wb_res;
    logic [REG_IDX_W-1:0] wb_rc;
    logic                 wb_rw;
    logic                 wb_rw_raw;

    logic accept;
    logic is_mem;

    assign accept = (state_q == IDLE) & en & ex_valid & ~flush;
    assign is_mem = memWrite | memToReg;

    // Next-state, access latch and MEM/WB load/clear decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rc_d    = rc_q;
        rw_d    = rw_q;
        ld_d    = ld_q;
        err_d   = err_q;
        wb_load = 1'b0;
        wb_clr  = 1'b0;
        wb_res  = '0;
        wb_rc   = '0;
        wb_rw   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && is_mem) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = memWrite;
                    addr_d  = aluOut[ADDR_W-1:0];
                    wdata_d = rd3;
                    rc_d    = Rc;
                    rw_d    = regWrite;
                    ld_d    = memToReg & ~memWrite;
                    wb_clr  = 1'b1;
                end else if (accept) begin
                    wb_load = 1'b1;
                    wb_res  = aluOut;
                    wb_rc   = Rc;
                    wb_rw   = regWrite;
                end else if (en) begin
                    wb_clr  = 1'b1;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    wb_load = 1'b1;
                    wb_res  = ld_q ? dmem_rdata : N'(addr_q);
                    wb_rc   = rc_q;
                    wb_rw   = rw_q;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    wb_load = 1'b1;
                    wb_res  = '0;
                    wb_rc   = rc_q;
                    wb_rw   = 1'b0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    wb_clr  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, timeout counter and data-memory interface registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rc_q    <= '0;
            rw_q    <= 1'b0;
            ld_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rc_q    <= rc_d;
            rw_q    <= rw_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
        end
    end

    mem_wb_reg #(
        .N(N)
    ) u_mem_wb_reg (
        .clk        (clk),
        .rst        (rst),
        .load_i     (wb_load),
        .clear_i    (wb_clr),
        .result_i   (wb_res),
        .rc_i       (wb_rc),
        .regwrite_i (wb_rw),
        .valid_o    (wb_valid),
        .result_o   (wb_result),
        .rc_o       (wb_Rc),
        .regwrite_o (wb_rw_raw)
    );

    assign wb_regWrite = wb_rw_raw & wb_valid;
    assign mem_stall   = (state_q == BUSY);
    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign mem_err     = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage.
// Table of ALU ops plus hand-written memory access sequences.
`timescale 1ns/1ps
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        en;
    logic        flush;
    logic        ex_valid;
    logic [31:0] aluOut;
    logic [31:0] rd3;
    logic [3:0]  Rc;
    logic        memWrite;
    logic        memToReg;
    logic        regWrite;
    logic        dmem_req;
    logic        dmem_we;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        mem_stall;
    logic        wb_valid;
    logic [31:0] wb_result;
    logic [3:0]  wb_Rc;
    logic        wb_regWrite;
    logic        mem_err;

    mem_stage #(
        .N(32),
        .ADDR_W(10),
        .TIMEOUT(15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .aluOut      (aluOut),
        .rd3         (rd3),
        .Rc          (Rc),
        .memWrite    (memWrite),
        .memToReg    (memToReg),
        .regWrite    (regWrite),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack),
        .mem_stall   (mem_stall),
        .wb_valid    (wb_valid),
        .wb_result   (wb_result),
        .wb_Rc       (wb_Rc),
        .wb_regWrite (wb_regWrite),
        .mem_err     (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  rc;
        logic        rw;
    } exp_t;

    typedef struct {
        logic [31:0] alu;
        logic [3:0]  rc;
        logic        rw;
        logic [31:0] e_res;
        logic [3:0]  e_rc;
        logic        e_rw;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];
    int   nvec;
    int   nerr;
    int   stalls;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] r, input logic mw,
                         input logic mr, input logic rw);
        en       = 1'b1;
        flush    = 1'b0;
        ex_valid = 1'b1;
        aluOut   = a;
        rd3      = d;
        Rc       = r;
        memWrite = mw;
        memToReg = mr;
        regWrite = rw;
    endtask

    task automatic quiet();
        en       = 1'b1;
        flush    = 1'b0;
        ex_valid = 1'b0;
        memWrite = 1'b0;
        memToReg = 1'b0;
    endtask

    task automatic push(input logic [31:0] res, input logic [3:0] r,
                        input logic rw);
        exp_t e;
        e.result = res;
        e.rc     = r;
        e.rw     = rw;
        sb.push_back(e);
    endtask

    task automatic check_wb(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL %s: scoreboard empty got 0 expected 1", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, ".valid"}, 32'(wb_valid), 32'd1);
            chk({nm, ".result"}, wb_result, e.result);
            chk({nm, ".rc"}, 32'(wb_Rc), 32'(e.rc));
            chk({nm, ".rw"}, 32'(wb_regWrite), 32'(e.rw));
        end
    endtask

    // Counts BUSY cycles until the access ends; ack_at=0 never acks.
    task automatic mem_access(input int ack_at, input logic [31:0] rdata,
                              output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!mem_stall) break;
            n++;
            if (n == ack_at) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            tick();
            dmem_ack = 1'b0;
        end
        if (mem_stall) begin
            nvec++;
            nerr++;
            $display("FAIL busy_bound: got stall 1 expected 0");
        end
    endtask

    initial begin
        nvec       = 0;
        nerr       = 0;
        rst        = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        aluOut     = '0;
        rd3        = '0;
        Rc         = '0;
        regWrite   = 1'b0;
        quiet();

        vecs[0] = '{32'h0000_0011, 4'd1,  1'b1, 32'h0000_0011, 4'd1,  1'b1};
        vecs[1] = '{32'hFFFF_FFFF, 4'd15, 1'b1, 32'hFFFF_FFFF, 4'd15, 1'b1};
        vecs[2] = '{32'h8000_0000, 4'd0,  1'b0, 32'h8000_0000, 4'd0,  1'b0};
        vecs[3] = '{32'h1234_5678, 4'd10, 1'b1, 32'h1234_5678, 4'd10, 1'b1};
        vecs[4] = '{32'h0000_0000, 4'd6,  1'b1, 32'h0000_0000, 4'd6,  1'b1};

        #1;
        chk("rst.req", 32'(dmem_req), 32'd0);
        chk("rst.stall", 32'(mem_stall), 32'd0);
        chk("rst.wb_valid", 32'(wb_valid), 32'd0);
        chk("rst.wb_result", wb_result, 32'd0);
        chk("rst.err", 32'(mem_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        drive(32'h2A, 32'h0, 4'd5, 1'b0, 1'b0, 1'b1);
        push(32'h2A, 4'd5, 1'b1);
        tick();
        check_wb("alu0");
        chk("alu0.stall", 32'(mem_stall), 32'd0);

        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].alu, 32'h0, vecs[i].rc, 1'b0, 1'b0, vecs[i].rw);
            push(vecs[i].e_res, vecs[i].e_rc, vecs[i].e_rw);
            tick();
            check_wb($sformatf("vec%0d", i));
        end
        quiet();
        tick();
        chk("bubble.valid", 32'(wb_valid), 32'd0);

        drive(32'h14, 32'h0, 4'd7, 1'b0, 1'b1, 1'b1);
        push(32'hDEAD_BEEF, 4'd7, 1'b1);
        tick();
        quiet();
        chk("ld.req", 32'(dmem_req), 32'd1);
        chk("ld.addr", 32'(dmem_addr), 32'h14);
        chk("ld.we", 32'(dmem_we), 32'd0);
        chk("ld.busy_valid", 32'(wb_valid), 32'd0);
        mem_access(3, 32'hDEAD_BEEF, stalls);
        chk("ld.stalls", 32'(stalls), 32'd3);
        check_wb("ld");
        chk("ld.req_off", 32'(dmem_req), 32'd0);
        tick();
        chk("ld.one_cycle", 32'(wb_valid), 32'd0);

        drive(32'h3, 32'h55, 4'd9, 1'b1, 1'b0, 1'b0);
        push(32'h3, 4'd9, 1'b0);
        tick();
        quiet();
        chk("st.we", 32'(dmem_we), 32'd1);
        chk("st.wdata", dmem_wdata, 32'h55);
        mem_access(1, 32'hFFFF_0000, stalls);
        chk("st.stalls", 32'(stalls), 32'd1);
        check_wb("st");

        drive(32'hFFFF_F7FF, 32'hA5A5_A5A5, 4'd8, 1'b1, 1'b1, 1'b1);
        push(32'h3FF, 4'd8, 1'b1);
        tick();
        quiet();
        chk("stld.we", 32'(dmem_we), 32'd1);
        chk("stld.addr", 32'(dmem_addr), 32'h3FF);
        mem_access(2, 32'h1111_1111, stalls);
        chk("stld.stalls", 32'(stalls), 32'd2);
        check_wb("stld");

        drive(32'h20, 32'h0, 4'd4, 1'b0, 1'b1, 1'b1);
        tick();
        quiet();
        mem_access(0, 32'h0, stalls);
        chk("to.stalls", 32'(stalls), 32'd15);
        chk("to.err", 32'(mem_err), 32'd1);
        chk("to.valid", 32'(wb_valid), 32'd1);
        chk("to.result", wb_result, 32'd0);
        chk("to.rw", 32'(wb_regWrite), 32'd0);
        chk("to.req", 32'(dmem_req), 32'd0);
        drive(32'h66, 32'h0, 4'd2, 1'b0, 1'b0, 1'b1);
        push(32'h66, 4'd2, 1'b1);
        tick();
        check_wb("post_to");
        chk("to.err_sticky", 32'(mem_err), 32'd1);

        quiet();
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("idle_ack.req", 32'(dmem_req), 32'd0);
        chk("idle_ack.stall", 32'(mem_stall), 32'd0);

        drive(32'h50, 32'h0, 4'd3, 1'b0, 1'b1, 1'b1);
        flush = 1'b1;
        tick();
        chk("flush.req", 32'(dmem_req), 32'd0);
        chk("flush.valid", 32'(wb_valid), 32'd0);

        drive(32'h77, 32'h0, 4'd3, 1'b0, 1'b0, 1'b1);
        push(32'h77, 4'd3, 1'b1);
        tick();
        check_wb("pre_hold");
        drive(32'h99, 32'h0, 4'd12, 1'b0, 1'b0, 1'b0);
        en = 1'b0;
        tick();
        tick();
        chk("hold.valid", 32'(wb_valid), 32'd1);
        chk("hold.result", wb_result, 32'h77);
        chk("hold.rc", 32'(wb_Rc), 32'd3);
        chk("hold.rw", 32'(wb_regWrite), 32'd1);
        quiet();
        tick();
        chk("clr.valid", 32'(wb_valid), 32'd0);
        chk("clr.result", wb_result, 32'h77);

        drive(32'h40, 32'h0, 4'd2, 1'b0, 1'b1, 1'b1);
        push(32'hCAFE_F00D, 4'd2, 1'b1);
        tick();
        drive(32'h88, 32'h0, 4'd1, 1'b0, 1'b0, 1'b1);
        flush = 1'b1;
        en    = 1'b0;
        mem_access(2, 32'hCAFE_F00D, stalls);
        quiet();
        chk("bflush.stalls", 32'(stalls), 32'd2);
        check_wb("bflush");

        drive(32'h30, 32'h0, 4'd6, 1'b0, 1'b1, 1'b1);
        tick();
        quiet();
        tick();
        chk("rstb.busy", 32'(mem_stall), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rstb.req", 32'(dmem_req), 32'd0);
        chk("rstb.stall", 32'(mem_stall), 32'd0);
        chk("rstb.err", 32'(mem_err), 32'd0);
        chk("rstb.addr", 32'(dmem_addr), 32'd0);
        chk("rstb.result", wb_result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        drive(32'h99, 32'h0, 4'd11, 1'b0, 1'b0, 1'b1);
        push(32'h99, 4'd11, 1'b1);
        tick();
        check_wb("post_rst");
        quiet();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
